vx_cache_rsp_coalesce: RTL
==========================

Name: vx_cache_rsp_coalesce

Overview:
- Successor to the cache core-response merge stage; sits between the per-bank response outputs and the core response port.
- Collects responses from NUM_BANKS banks, each with NUM_PORTS lanes, and coalesces all banks whose tag IDs match into one multi-lane core response.
- Adds round-robin leader selection, explicit resolution of lane-tid collisions, and a parametrised-depth output FIFO.
- Replaces the fixed-priority, single-slot behaviour of the prior stage.

Parameters:
- NUM_REQS, 4: core lanes. Power of 2, ≥2. REQ_BITS = log2(NUM_REQS).
- NUM_BANKS, 4: banks, ≥2. BANK_BITS = log2(NUM_BANKS), min 1.
- NUM_PORTS, 1: lanes per bank, ≥1.
- WORD_SIZE, 4: bytes per word. WORD_W = 8*WORD_SIZE.
- TAG_WIDTH, 8: core tag width.
- TAG_ID_BITS, 4: low tag bits used for matching. Range 0..TAG_WIDTH. A value of 0 disables merging.
- OUT_DEPTH, 2: output FIFO entries. Power of 2, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- per_bank_rsp_valid  in  NUM_BANKS  bank response valid
- per_bank_rsp_pmask  in  NUM_BANKS*NUM_PORTS  active lanes per bank
- per_bank_rsp_tid  in  NUM_BANKS*NUM_PORTS*REQ_BITS  destination core lane per bank lane
- per_bank_rsp_data  in  NUM_BANKS*NUM_PORTS*WORD_W  response data
- per_bank_rsp_tag  in  NUM_BANKS*TAG_WIDTH  response tag
- per_bank_rsp_ready  out  NUM_BANKS  bank response accepted this cycle
- core_rsp_valid  out  NUM_REQS  per-lane valid
- core_rsp_tag  out  TAG_WIDTH  response tag
- core_rsp_data  out  NUM_REQS*WORD_W  per-lane data
- core_rsp_ready  in  1  core accepts the whole response
- perf_merge_cnt  out  32  count of pushes that contained more than one bank

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO count, write pointer and read pointer cleared to 0.
  - rr_ptr cleared to 0.
  - perf_merge_cnt cleared to 0.
  - Consequently core_rsp_valid=0, core_rsp_tag=0, core_rsp_data=0 and per_bank_rsp_ready=0.
  - Entries in flight are dropped.
- Leader selection: the first bank with valid=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ...). No valid bank means no leader and no push.
- Candidates: a valid bank is a candidate if its tag[TAG_ID_BITS-1:0] equals the leader's. With TAG_ID_BITS=0, only the leader is a candidate.
- Collision resolution:
  - Candidates are visited in the same cyclic order starting at the leader.
  - A candidate is selected only if none of its pmask-active lanes' tids are already claimed by a previously selected bank.
  - Selection is all-or-nothing per bank; a non-selected bank is retried in a later cycle.
  - Within one bank, duplicate tids across active lanes: the higher port index wins.
- Accept: accept = leader exists AND FIFO not full. per_bank_rsp_ready[i] = accept AND selected[i]. This is combinational, and no ready signal depends on core_rsp_ready.
- Push (on accept): the FIFO writes {lane_mask, leader tag, lane data}.
  - lane_mask[t]=1 for every tid claimed.
  - Unclaimed lanes carry data 0.
  - rr_ptr <= (leader+1) mod NUM_BANKS. rr_ptr holds when there is no accept.
- FIFO full: a push is blocked when count==OUT_DEPTH, even if a pop occurs in the same cycle. There is no pass-through.
- FIFO empty: outputs read 0.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance. Pointers wrap mod OUT_DEPTH.
- Output:
  - core_rsp_valid = {NUM_REQS{count!=0}} & head.lane_mask.
  - core_rsp_tag and core_rsp_data are taken from the head entry.
  - Pop when (count!=0) AND core_rsp_ready.
  - Outputs are driven directly from FIFO registers.
- Latency: a bank accepted in cycle N appears at the output in cycle N+1, provided all earlier entries have drained.
- perf_merge_cnt increments on each push with more than one selected bank, and wraps at 2^32.
- A bank holds valid, tag and data stable until its ready is asserted. The bench checks this with an assertion.

Test Plan:
- Reset:
  - Assert reset while banks 0–3 are valid → per_bank_rsp_ready=0000, core_rsp_valid=0000, tag=0x00, data=0.
  - Deassert reset → bank 0 is accepted first.
- Merge: banks 0 and 2 valid, tags 0x15 and 0x25 (ID 5), tids 0 and 2, data 0xAAAA0000 and 0xBBBB0000 → per_bank_rsp_ready=0101. Next cycle: core_rsp_valid=0101, tag=0x15, lane0=0xAAAA0000, lane2=0xBBBB0000, lanes 1 and 3 = 0, perf_merge_cnt=1.
- Round-robin: banks 0 and 1 both valid with IDs 3 and 4, core_rsp_ready=1 → bank 0 acked (rr_ptr 0→1), then bank 1 acked (rr_ptr 1→2). A new bank 0 request arriving while bank 3 is valid with rr_ptr=2 → bank 3 wins.
- Collision: banks 1 and 3 both ID 7, both tid 2, rr_ptr=0 → ready=0010. Next cycle ready=1000. Two outputs result, each with core_rsp_valid=0100.
- Backpressure with OUT_DEPTH=2 and core_rsp_ready=0: two pushes occur, then ready=0000 while banks stay valid. Set core_rsp_ready=1 for one cycle → one pop, and the next cycle accepts a bank (no same-cycle push on full).
- Mid-operation reset: FIFO holds 2 entries and a bank is valid; pulse reset between clock edges → core_rsp_valid drops to 0000 before the next edge and count=0. After release the bank is re-accepted, with rr_ptr restarting at 0.

Source files
------------

// File: rtl/vx_cache_rsp_coalesce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vx_cache_rsp_coalesce                                          |
// | Merges tag-matching per-bank responses into one core response.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vx_cache_rsp_coalesce #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_PORTS   = 1,
  parameter int WORD_SIZE   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int TAG_ID_BITS = 4,
  parameter int OUT_DEPTH   = 2
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_BANKS-1:0]                                   per_bank_rsp_valid,
  input  logic [NUM_BANKS*NUM_PORTS-1:0]                         per_bank_rsp_pmask,
  input  logic [NUM_BANKS*NUM_PORTS*$clog2(NUM_REQS)-1:0]        per_bank_rsp_tid,
  input  logic [NUM_BANKS*NUM_PORTS*8*WORD_SIZE-1:0]             per_bank_rsp_data,
  input  logic [NUM_BANKS*TAG_WIDTH-1:0]                         per_bank_rsp_tag,
  output logic [NUM_BANKS-1:0]                                   per_bank_rsp_ready,
  output logic [NUM_REQS-1:0]                                    core_rsp_valid,
  output logic [TAG_WIDTH-1:0]                                   core_rsp_tag,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]                        core_rsp_data,
  input  logic                                                   core_rsp_ready,
  output logic [31:0]                                            perf_merge_cnt
);

  localparam int c_req_bits  = $clog2(NUM_REQS);
  localparam int c_bank_bits = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int c_word_w    = 8 * WORD_SIZE;
  localparam int c_ptr_w     = $clog2(OUT_DEPTH);
  localparam int c_cnt_w     = c_ptr_w + 1;
  localparam logic [TAG_WIDTH-1:0] c_id_mask = {TAG_WIDTH{1'b1}} >> (TAG_WIDTH - TAG_ID_BITS);

  logic [c_bank_bits-1:0]          r_rr_ptr;
  logic [c_cnt_w-1:0]              r_count;
  logic [c_ptr_w-1:0]              r_wr_ptr;
  logic [c_ptr_w-1:0]              r_rd_ptr;
  logic [31:0]                     r_perf;
  logic [NUM_REQS-1:0]             r_mem_mask [OUT_DEPTH];
  logic [TAG_WIDTH-1:0]            r_mem_tag  [OUT_DEPTH];
  logic [NUM_REQS*c_word_w-1:0]    r_mem_data [OUT_DEPTH];

  logic                            w_found;
  logic [c_bank_bits-1:0]          w_leader;
  logic [TAG_WIDTH-1:0]            w_leader_tag;
  logic [c_bank_bits-1:0]          w_bank;
  logic                            w_match;
  logic                            w_conflict;
  logic [c_req_bits-1:0]           w_tid;
  logic [NUM_BANKS-1:0]            w_sel;
  logic [NUM_REQS-1:0]             w_claim;
  logic [NUM_REQS*c_word_w-1:0]    w_data;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_nonempty;

  function automatic logic [c_bank_bits-1:0] wrap_add(input logic [c_bank_bits-1:0] base,
                                                      input int off);
    int s;
    s = int'(base) + off;
    return c_bank_bits'(s % NUM_BANKS);
  endfunction

  // Leader search, then greedy all-or-nothing claiming of lanes in cyclic order from the leader.
  always_comb begin
    w_found      = 1'b0;
    w_leader     = '0;
    w_leader_tag = '0;
    w_bank       = '0;
    w_match      = 1'b0;
    w_conflict   = 1'b0;
    w_tid        = '0;
    w_sel        = '0;
    w_claim      = '0;
    w_data       = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (!w_found && per_bank_rsp_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_leader = wrap_add(r_rr_ptr, k);
      end
    end
    w_leader_tag = per_bank_rsp_tag[int'(w_leader)*TAG_WIDTH +: TAG_WIDTH];
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_bank  = wrap_add(w_leader, k);
      w_match = (TAG_ID_BITS == 0) ? (k == 0)
              : (((per_bank_rsp_tag[int'(w_bank)*TAG_WIDTH +: TAG_WIDTH] ^ w_leader_tag)
                  & c_id_mask) == '0);
      w_conflict = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_tid = per_bank_rsp_tid[(int'(w_bank)*NUM_PORTS + p)*c_req_bits +: c_req_bits];
        if (per_bank_rsp_pmask[int'(w_bank)*NUM_PORTS + p] && w_claim[w_tid])
          w_conflict = 1'b1;
      end
      if (w_found && per_bank_rsp_valid[w_bank] && w_match && !w_conflict) begin
        w_sel[w_bank] = 1'b1;
        // Ascending port order lets the higher port overwrite a duplicate tid.
        for (int p = 0; p < NUM_PORTS; p++) begin
          w_tid = per_bank_rsp_tid[(int'(w_bank)*NUM_PORTS + p)*c_req_bits +: c_req_bits];
          if (per_bank_rsp_pmask[int'(w_bank)*NUM_PORTS + p]) begin
            w_claim[w_tid] = 1'b1;
            w_data[int'(w_tid)*c_word_w +: c_word_w] =
              per_bank_rsp_data[(int'(w_bank)*NUM_PORTS + p)*c_word_w +: c_word_w];
          end
        end
      end
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_push     = w_found && (r_count != c_cnt_w'(OUT_DEPTH));
  assign w_pop      = w_nonempty && core_rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_perf   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_leader == c_bank_bits'(NUM_BANKS - 1)) ? '0 : w_leader + 1'b1;
        if ($countones(w_sel) > 1)
          r_perf <= r_perf + 32'd1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_mask[r_wr_ptr] <= w_claim;
      r_mem_tag[r_wr_ptr]  <= w_leader_tag;
      r_mem_data[r_wr_ptr] <= w_data;
    end
  end

  assign per_bank_rsp_ready = (w_push && !reset) ? w_sel : '0;
  assign core_rsp_valid     = w_nonempty ? r_mem_mask[r_rd_ptr] : '0;
  assign core_rsp_tag       = w_nonempty ? r_mem_tag[r_rd_ptr]  : '0;
  assign core_rsp_data      = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
  assign perf_merge_cnt     = r_perf;

endmodule
`default_nettype wire
